column_render: RTL and testbench

- Parametrised successor to the single-buffer wall renderer in the raybox top level.
- Holds a double-buffered (ping-pong) store of per-column wall height and side. The tracer can fill one bank at any time while the other bank is scanned out.
- Converts the VGA beam position into registered RGB with a fixed 2-cycle pipeline.
- Sits between vga_sync and tracer, replacing the trace_buffer, in_wall and colour logic in the top level.

---
 rtl/column_render.sv | 148 ++++++++++++++
 tb/tb_column_render.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_render.sv
// column_render: double-buffered per-column wall store with a 2-cycle
// beam-to-RGB pipeline.
//
// The tracer fills the write bank (always !disp_bank) through wr_valid/wr_ready
// and requests a bank swap with a commit pulse. The swap happens at the start
// of VBLANK (v == V_RES, h == 0). Scan-out reads only the display bank.
//
// Ports:
//   clk, reset                 pixel clock, synchronous active-high reset
//   h, v, visible              beam position from vga_sync
//   wr_valid, wr_ready         column write handshake (wr_ready = !swap_pending)
//   wr_column/height/side      column write payload
//   commit, swap_pending       swap request / request outstanding
//   disp_bank                  bank currently scanned out
//   red, green, blue           registered colour, 2 cycles after h/v/visible
//
// Optional build macro COLUMN_RENDER_SHADE_EN: wall blue is scaled by height
// (brighter when nearer) instead of the flat side colour.
module column_render #(
  parameter int unsigned      H_RES     = 640,
  parameter int unsigned      V_RES     = 480,
  parameter int unsigned      COL_W     = 10,
  parameter int unsigned      HEIGHT_W  = 9,
  parameter int unsigned      BPC       = 2,
  parameter logic [3*BPC-1:0] CEIL_RGB  = 6'b010101,
  parameter logic [3*BPC-1:0] FLOOR_RGB = 6'b101010
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          h,
  input  logic [9:0]          v,
  input  logic                visible,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [COL_W-1:0]    wr_column,
  input  logic [HEIGHT_W-1:0] wr_height,
  input  logic                wr_side,
  input  logic                commit,
  output logic                swap_pending,
  output logic                disp_bank,
  output logic [BPC-1:0]      red,
  output logic [BPC-1:0]      green,
  output logic [BPC-1:0]      blue
);

  localparam int unsigned    HALF = V_RES / 2;
  localparam logic [BPC-1:0] MAX  = '1;

  // Each entry is {side, height}.
  logic [HEIGHT_W:0] bank0 [H_RES];
  logic [HEIGHT_W:0] bank1 [H_RES];

  logic                wr_en;
  logic [COL_W-1:0]    rd_col;
  logic [HEIGHT_W-1:0] s1_height;
  logic                s1_side;
  logic [9:0]          s1_v;
  logic                s1_visible;

  assign wr_ready = ~swap_pending;
  assign rd_col   = COL_W'(h);
  // Out-of-range columns are accepted by the handshake but never stored.
  assign wr_en    = !reset && wr_valid && wr_ready && (32'(wr_column) < H_RES);

  // Bank storage: the write bank is the one not being displayed.
  always_ff @(posedge clk) begin
    if (wr_en && disp_bank)  bank0[wr_column] <= {wr_side, wr_height};
    if (wr_en && !disp_bank) bank1[wr_column] <= {wr_side, wr_height};
  end

  // Stage 1: synchronous read of the display bank at the beam column.
  always_ff @(posedge clk) begin
    s1_v <= v;
    if (32'(h) >= H_RES)  {s1_side, s1_height} <= '0;
    else if (disp_bank)   {s1_side, s1_height} <= bank1[rd_col];
    else                  {s1_side, s1_height} <= bank0[rd_col];
  end

  // Bank control. A swap at VBLANK start takes priority; a commit seen in
  // that same cycle is only honoured when nothing was pending, so it waits
  // for the following frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_bank    <= 1'b0;
      swap_pending <= 1'b0;
      s1_visible   <= 1'b0;
    end else begin
      s1_visible <= visible;
      if (swap_pending && v == 10'(V_RES) && h == '0) begin
        disp_bank    <= ~disp_bank;
        swap_pending <= 1'b0;
      end else if (commit && !swap_pending) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Stage 2 wall test: rows [HALF-ht, HALF+ht) with ht clamped to HALF.
  logic [HEIGHT_W-1:0] ht;
  logic [31:0]         v_ext;
  logic [31:0]         ht_ext;
  logic                in_wall;
  logic [BPC-1:0]      wall_blue;

  always_comb begin
    ht      = (32'(s1_height) > HALF) ? HEIGHT_W'(HALF) : s1_height;
    v_ext   = 32'(s1_v);
    ht_ext  = 32'(ht);
    in_wall = (v_ext + ht_ext >= HALF) && (v_ext < HALF + ht_ext);
  end

`ifdef COLUMN_RENDER_SHADE_EN
  logic [HEIGHT_W-1:0] shifted;
  logic [BPC-1:0]      near;

  // Keep the top BPC+1 height bits, floor at 1, saturate at MAX; the dark
  // side is halved again but never goes fully black.
  always_comb begin
    shifted = ht >> (HEIGHT_W - 1 - BPC);
    if (shifted == '0)                  near = BPC'(1);
    else if (shifted > HEIGHT_W'(MAX))  near = MAX;
    else                                near = BPC'(shifted);
    wall_blue = near;
    if (!s1_side) begin
      wall_blue = near >> 1;
      if (wall_blue == '0) wall_blue = BPC'(1);
    end
  end
`else
  assign wall_blue = s1_side ? MAX : MAX - BPC'(1);
`endif

  // Stage 2: registered colour.
  always_ff @(posedge clk) begin
    if (reset) begin
      {red, green, blue} <= '0;
    end else if (!s1_visible) begin
      {red, green, blue} <= '0;
    end else if (in_wall) begin
      {red, green, blue} <= {{(2*BPC){1'b0}}, wall_blue};
    end else if (32'(s1_v) < HALF) begin
      {red, green, blue} <= CEIL_RGB;
    end else begin
      {red, green, blue} <= FLOOR_RGB;
    end
  end

endmodule

// File: tb/tb_column_render.sv
// Self-checking bench for column_render: a behavioural model (banks as
// integer arrays, colour from the height/row rules) is compared on every
// cycle, plus literal expectations at key points.
module tb_column_render;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] h = '0;
  logic [9:0] v = '0;
  logic       visible = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [9:0] wr_column = '0;
  logic [8:0] wr_height = '0;
  logic       wr_side = 1'b0;
  logic       commit = 1'b0;
  logic       swap_pending;
  logic       disp_bank;
  logic [1:0] red, green, blue;

  always #5 clk = ~clk;

  column_render dut (
    .clk(clk), .reset(reset), .h(h), .v(v), .visible(visible),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_column(wr_column),
    .wr_height(wr_height), .wr_side(wr_side), .commit(commit),
    .swap_pending(swap_pending), .disp_bank(disp_bank),
    .red(red), .green(green), .blue(blue)
  );

  int checks = 0;
  int errors = 0;

`ifdef COLUMN_RENDER_SHADE_EN
  localparam logic [5:0] W100_S1 = 6'd1;  // ht 100 -> 100/64 = 1
  localparam logic [5:0] W50_S1  = 6'd1;  // ht 50 -> 0, floored to 1
  localparam logic [5:0] W240_S0 = 6'd1;  // 3 halved -> 1
  localparam logic [5:0] W240_S1 = 6'd3;
  localparam logic [5:0] W16_S1  = 6'd1;
`else
  localparam logic [5:0] W100_S1 = 6'd3;
  localparam logic [5:0] W50_S1  = 6'd3;
  localparam logic [5:0] W240_S0 = 6'd2;
  localparam logic [5:0] W240_S1 = 6'd3;
  localparam logic [5:0] W16_S1  = 6'd3;
`endif

  task automatic check(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Colour from the rules: no wall outside the visible area, wall rows are
  // the 2*ht rows centred on the horizon, sky above and floor below.
  function automatic logic [5:0] colour(input int height, input int side,
                                        input int row, input bit vis);
    int ht;
    int b;
    if (!vis) return 6'd0;
    ht = (height > 240) ? 240 : height;
    if (row >= 240 - ht && row < 240 + ht) begin
`ifdef COLUMN_RENDER_SHADE_EN
      b = ht / 64;
      if (b < 1) b = 1;
      if (b > 3) b = 3;
      if (side == 0) begin
        b = b / 2;
        if (b < 1) b = 1;
      end
`else
      b = (side != 0) ? 3 : 2;
`endif
      return 6'(b);
    end
    return (row < 240) ? 6'b010101 : 6'b101010;
  endfunction

  // Reference model state.
  int         mh [2][640];
  int         ms [2][640];
  int         m_disp = 0;
  int         m_pend = 0;
  logic [5:0] exp1 = '0;
  logic [5:0] exp2 = '0;
  bit         started = 1'b0;

  always @(posedge clk) begin
    int hgt;
    int sd;
    if (reset) begin
      m_disp  = 0;
      m_pend  = 0;
      exp1    = '0;
      exp2    = '0;
      started = 1'b1;
    end else begin
      hgt  = (h < 640) ? mh[m_disp][h] : 0;
      sd   = (h < 640) ? ms[m_disp][h] : 0;
      exp2 = exp1;
      exp1 = colour(hgt, sd, int'(v), visible);
      if (wr_valid && m_pend == 0 && wr_column < 640) begin
        mh[1 - m_disp][wr_column] = int'(wr_height);
        ms[1 - m_disp][wr_column] = int'(wr_side);
      end
      if (m_pend != 0 && v == 480 && h == 0) begin
        m_disp = 1 - m_disp;
        m_pend = 0;
      end else if (commit && m_pend == 0) begin
        m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("rgb", int'({red, green, blue}), int'(exp2));
      check("disp_bank", int'(disp_bank), m_disp);
      check("swap_pending", int'(swap_pending), m_pend);
      check("wr_ready", int'(wr_ready), (m_pend == 0) ? 1 : 0);
    end
  end

  // Present one cycle of inputs; returns just after the sampling edge.
  task automatic cyc(input int hh, input int vv, input bit vis,
                     input bit wv = 1'b0, input int wc = 0, input int wh = 0,
                     input bit ws = 1'b0, input bit cm = 1'b0,
                     input bit rs = 1'b0);
    h         = 10'(hh);
    v         = 10'(vv);
    visible   = vis;
    wr_valid  = wv;
    wr_column = 10'(wc);
    wr_height = 9'(wh);
    wr_side   = ws;
    commit    = cm;
    reset     = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic vblank();
    cyc(0, 480, 1'b0);
  endtask

  task automatic probe(input int hh, input int vv, input logic [5:0] e,
                       input string nm);
    cyc(hh, vv, 1'b1);
    cyc(hh, vv, 1'b1);
    check(nm, int'({red, green, blue}), int'(e));
  endtask

  task automatic sweep_column(input int hh);
    for (int r = 0; r < 480; r++) cyc(hh, r, 1'b1);
  endtask

  initial begin
    // Reset
    cyc(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    cyc(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    check("reset_disp", int'(disp_bank), 0);
    check("reset_pending", int'(swap_pending), 0);
    check("reset_ready", int'(wr_ready), 1);
    check("reset_rgb", int'({red, green, blue}), 0);

    // Fill both banks with random columns so every read is known.
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < 640; c++)
        cyc(c, 0, 1'b0, 1'b1, c, int'($urandom_range(0, 511)), 1'($urandom));
      cyc(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
      vblank();
    end
    check("fill_disp", int'(disp_bank), 0);

    // Bank swap
    cyc(0, 0, 1'b0, 1'b1, 5, 100, 1'b1);
    cyc(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    check("commit_pending", int'(swap_pending), 1);
    vblank();
    check("swap_disp", int'(disp_bank), 1);
    check("swap_pending_clr", int'(swap_pending), 0);
    check("swap_ready", int'(wr_ready), 1);
    for (int r = 130; r < 350; r++) cyc(5, r, 1'b1);
    probe(5, 140, W100_S1, "wall_top");
    probe(5, 339, W100_S1, "wall_bottom");
    probe(5, 139, 6'b010101, "above_wall");
    probe(5, 340, 6'b101010, "below_wall");

    // Latency
    cyc(5, 200, 1'b0);
    cyc(5, 200, 1'b1);
    check("latency_n1", int'({red, green, blue}), 0);
    cyc(5, 200, 1'b0);
    check("latency_n2", int'({red, green, blue}), int'(W100_S1));
    cyc(5, 200, 1'b0);
    check("latency_invisible", int'({red, green, blue}), 0);

    // Write lock
    cyc(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    cyc(0, 0, 1'b0, 1'b1, 7, 50, 1'b1);
    check("lock_ready", int'(wr_ready), 0);
    vblank();
    check("lock_swap_disp", int'(disp_bank), 0);
    sweep_column(7);
    check("unlock_ready", int'(wr_ready), 1);
    cyc(0, 0, 1'b0, 1'b1, 7, 50, 1'b1);
    cyc(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    vblank();
    probe(7, 200, W50_S1, "col7_wall");
    probe(7, 189, 6'b010101, "col7_above");

    // Clamp, zero height and out-of-range column
    cyc(0, 0, 1'b0, 1'b1, 9, 300, 1'b0);
    cyc(0, 0, 1'b0, 1'b1, 10, 0, 1'b1);
    cyc(0, 0, 1'b0, 1'b1, 640, 77, 1'b1);
    check("col640_ready", int'(wr_ready), 1);
    cyc(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    vblank();
    sweep_column(9);
    probe(9, 0, W240_S0, "clamp_row0");
    probe(9, 479, W240_S0, "clamp_row479");
    probe(10, 100, 6'b010101, "zero_ceiling");
    probe(10, 300, 6'b101010, "zero_floor");
    probe(700, 300, 6'b101010, "h_out_of_range");

    // Commit in the swap-start cycle with nothing pending
    cyc(0, 480, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    check("late_commit_pending", int'(swap_pending), 1);
    check("late_commit_no_swap", int'(disp_bank), 0);
    cyc(0, 0, 1'b0);
    vblank();
    check("late_commit_swap", int'(disp_bank), 1);

    // Shade / flat wall colours
    cyc(0, 0, 1'b0, 1'b1, 20, 240, 1'b1);
    cyc(0, 0, 1'b0, 1'b1, 21, 240, 1'b0);
    cyc(0, 0, 1'b0, 1'b1, 22, 16, 1'b1);
    cyc(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    vblank();
    probe(20, 239, W240_S1, "shade_240_s1");
    probe(21, 239, W240_S0, "shade_240_s0");
    probe(22, 239, W16_S1, "shade_16_s1");

    // Reset while pending; the write in the reset cycle is dropped
    cyc(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    check("pre_reset_pending", int'(swap_pending), 1);
    cyc(0, 0, 1'b0, 1'b1, 3, 11, 1'b1, 1'b0, 1'b1);
    check("reset_drops_pending", int'(swap_pending), 0);
    check("reset_disp_zero", int'(disp_bank), 0);
    cyc(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    vblank();
    sweep_column(3);

    // Randomized traffic
    for (int i = 0; i < 20000; i++) begin
      int hh;
      int vv;
      hh = int'($urandom_range(0, 700));
      vv = int'($urandom_range(0, 519));
      if ($urandom_range(0, 63) == 0) begin
        hh = 0;
        vv = 480;
      end
      cyc(hh, vv, ($urandom_range(0, 3) != 0),
          1'($urandom), int'($urandom_range(0, 659)),
          int'($urandom_range(0, 511)), 1'($urandom),
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 1999) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
